// File: rtl/hazard_pkg.sv
// Shared types and default widths for the ID-stage hazard/stall sequencer.
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN,
    MC_BUSY
  } state_e;

  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned LAT_W_DEF  = 4;
  localparam int unsigned CNT_W_DEF  = 16;

endpackage

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction reading the rd of a load in EX.
module load_use_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] ifidRs1_i,
  input  logic [REG_AW-1:0] ifidRs2_i,
  input  logic              idexMemRead_i,
  input  logic [REG_AW-1:0] idexRd_i,
  output logic              loadUse_o
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  always_comb begin
    loadUse_o = idexMemRead_i && (idexRd_i != '0) &&
                ((idexRd_i == ifidRs1_i) || (idexRd_i == ifidRs2_i));
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard and stall sequencer: load-use bubbles, multi-cycle front-end holds,
// taken-branch flushes and a saturating stall-cycle performance counter.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned LAT_W  = LAT_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [REG_AW-1:0] IFID_RS1_i,
  input  logic [REG_AW-1:0] IFID_RS2_i,
  input  logic              IDEX_MemRead_i,
  input  logic [REG_AW-1:0] IDEX_RD_i,
  input  logic              MC_start_i,
  input  logic [LAT_W-1:0]  MC_lat_i,
  input  logic              Branch_taken_i,
  output logic              Hazard_o,
  output logic              PCWrite_o,
  output logic              IFIDWrite_o,
  output logic              IFIDFlush_o,
  output logic              Busy_o,
  output logic [CNT_W-1:0]  Stall_cnt_o
);

  state_e             state_q;
  logic   [LAT_W-1:0] cnt_q;
  logic   [CNT_W-1:0] stallCnt_q;
  logic               loadUse;
  logic               mcAccept;

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_load_use_detect (
    .ifidRs1_i    (IFID_RS1_i),
    .ifidRs2_i    (IFID_RS2_i),
    .idexMemRead_i(IDEX_MemRead_i),
    .idexRd_i     (IDEX_RD_i),
    .loadUse_o    (loadUse)
  );

  // Pipeline control decode; reset holds the front end frozen behind a bubble.
  always_comb begin
    Hazard_o    = 1'b0;
    PCWrite_o   = 1'b1;
    IFIDWrite_o = 1'b1;
    IFIDFlush_o = 1'b0;
    Busy_o      = 1'b0;
    mcAccept    = 1'b0;
    if (!rst_n_i) begin
      Hazard_o    = 1'b1;
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
    end else if (state_q == MC_BUSY) begin
      Hazard_o    = 1'b1;
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      Busy_o      = 1'b1;
    end else if (Branch_taken_i) begin
      // ID holds a wrong-path instruction: squash it, let the PC take the target.
      Hazard_o    = 1'b1;
      IFIDFlush_o = 1'b1;
    end else if (loadUse) begin
      // Multi-cycle op (if any) stays held in ID and is retried next cycle.
      Hazard_o    = 1'b1;
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
    end else if (MC_start_i && (MC_lat_i != '0)) begin
      mcAccept = 1'b1;
    end
  end

  // FSM and multi-cycle down-counter; leave MC_BUSY on the edge where cnt reaches 1.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mcAccept) begin
            cnt_q   <= MC_lat_i;
            state_q <= MC_BUSY;
          end
        end
        MC_BUSY: begin
          cnt_q <= cnt_q - LAT_W'(1);
          if (cnt_q == LAT_W'(1)) begin
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Saturating stall-cycle counter; flush cycles keep PCWrite high and are not counted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stallCnt_q <= '0;
    end else if (!PCWrite_o && (stallCnt_q != '1)) begin
      stallCnt_q <= stallCnt_q + CNT_W'(1);
    end
  end

  assign Stall_cnt_o = stallCnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (4-bit stall counter to reach saturation).
module tb_hazard_stall_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [4:0] IFID_RS1_i;
  logic [4:0] IFID_RS2_i;
  logic       IDEX_MemRead_i;
  logic [4:0] IDEX_RD_i;
  logic       MC_start_i;
  logic [3:0] MC_lat_i;
  logic       Branch_taken_i;
  logic       Hazard_o;
  logic       PCWrite_o;
  logic       IFIDWrite_o;
  logic       IFIDFlush_o;
  logic       Busy_o;
  logic [3:0] Stall_cnt_o;

  int errors = 0;
  int checks = 0;

  // Output vector order: {Hazard, PCWrite, IFIDWrite, IFIDFlush, Busy}
  logic [4:0] outs;
  assign outs = {Hazard_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o, Busy_o};

  localparam logic [4:0] OUT_RST   = 5'b10000;
  localparam logic [4:0] OUT_RUN   = 5'b01100;
  localparam logic [4:0] OUT_LU    = 5'b10000;
  localparam logic [4:0] OUT_BUSY  = 5'b10001;
  localparam logic [4:0] OUT_FLUSH = 5'b11110;

  hazard_stall_ctrl #(
    .REG_AW(5),
    .LAT_W (4),
    .CNT_W (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .IFID_RS1_i    (IFID_RS1_i),
    .IFID_RS2_i    (IFID_RS2_i),
    .IDEX_MemRead_i(IDEX_MemRead_i),
    .IDEX_RD_i     (IDEX_RD_i),
    .MC_start_i    (MC_start_i),
    .MC_lat_i      (MC_lat_i),
    .Branch_taken_i(Branch_taken_i),
    .Hazard_o      (Hazard_o),
    .PCWrite_o     (PCWrite_o),
    .IFIDWrite_o   (IFIDWrite_o),
    .IFIDFlush_o   (IFIDFlush_o),
    .Busy_o        (Busy_o),
    .Stall_cnt_o   (Stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle();
    IFID_RS1_i     = '0;
    IFID_RS2_i     = '0;
    IDEX_MemRead_i = 1'b0;
    IDEX_RD_i      = '0;
    MC_start_i     = 1'b0;
    MC_lat_i       = '0;
    Branch_taken_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    idle();
    rst_n_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst_n_i = 1'b0;
    #3;
    checks++;
    if (outs !== OUT_RST) begin
      errors++; $display("FAIL reset_outs: got %b want %b", outs, OUT_RST);
    end
    checks++;
    if (Stall_cnt_o !== 4'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", Stall_cnt_o);
    end
    tick();
    tick();
    checks++;
    if (Stall_cnt_o !== 4'd0) begin
      errors++; $display("FAIL reset_hold_cnt: got %0d want 0", Stall_cnt_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick();
    checks++;
    if (outs !== OUT_RUN) begin
      errors++; $display("FAIL reset_release_outs: got %b want %b", outs, OUT_RUN);
    end
  endtask

  task automatic test_load_use();
    IDEX_MemRead_i = 1'b1; IDEX_RD_i = 5'd5; IFID_RS1_i = 5'd5; IFID_RS2_i = 5'd0;
    #1;
    checks++;
    if (outs !== OUT_LU) begin
      errors++; $display("FAIL lu_rs1_outs: got %b want %b", outs, OUT_LU);
    end
    tick();
    idle();
    #1;
    checks++;
    if (outs !== OUT_RUN || Stall_cnt_o !== 4'd1) begin
      errors++; $display("FAIL lu_rs1_after: got %b cnt %0d want %b cnt 1", outs, Stall_cnt_o,
                         OUT_RUN);
    end
    // Load into x0: no dependency
    IDEX_MemRead_i = 1'b1; IDEX_RD_i = 5'd0; IFID_RS1_i = 5'd0; IFID_RS2_i = 5'd0;
    #1;
    checks++;
    if (outs !== OUT_RUN) begin
      errors++; $display("FAIL lu_x0_outs: got %b want %b", outs, OUT_RUN);
    end
    tick();
    checks++;
    if (Stall_cnt_o !== 4'd1) begin
      errors++; $display("FAIL lu_x0_cnt: got %0d want 1", Stall_cnt_o);
    end
    // Match on rs2
    IDEX_MemRead_i = 1'b1; IDEX_RD_i = 5'd7; IFID_RS1_i = 5'd3; IFID_RS2_i = 5'd7;
    #1;
    checks++;
    if (outs !== OUT_LU) begin
      errors++; $display("FAIL lu_rs2_outs: got %b want %b", outs, OUT_LU);
    end
    tick();
    checks++;
    if (Stall_cnt_o !== 4'd2) begin
      errors++; $display("FAIL lu_rs2_cnt: got %0d want 2", Stall_cnt_o);
    end
    // Same registers but not a load
    IDEX_MemRead_i = 1'b0;
    #1;
    checks++;
    if (outs !== OUT_RUN) begin
      errors++; $display("FAIL lu_noload_outs: got %b want %b", outs, OUT_RUN);
    end
    idle();
  endtask

  task automatic test_multicycle();
    apply_reset();
    MC_start_i = 1'b1; MC_lat_i = 4'd3;
    #1;
    checks++;
    if (outs !== OUT_RUN) begin
      errors++; $display("FAIL mc_issue_outs: got %b want %b", outs, OUT_RUN);
    end
    tick();
    idle();
    for (int i = 1; i <= 3; i++) begin
      Branch_taken_i = (i == 2);  // must be ignored while busy
      #1;
      checks++;
      if (outs !== OUT_BUSY || Stall_cnt_o !== 4'(i - 1)) begin
        errors++; $display("FAIL mc_busy_%0d: got %b cnt %0d want %b cnt %0d", i, outs,
                           Stall_cnt_o, OUT_BUSY, i - 1);
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if (outs !== OUT_RUN || Stall_cnt_o !== 4'd3) begin
      errors++; $display("FAIL mc_done: got %b cnt %0d want %b cnt 3", outs, Stall_cnt_o,
                         OUT_RUN);
    end
    MC_start_i = 1'b1; MC_lat_i = 4'd0;
    #1;
    checks++;
    if (outs !== OUT_RUN) begin
      errors++; $display("FAIL mc_lat0_issue: got %b want %b", outs, OUT_RUN);
    end
    tick();
    idle();
    #1;
    checks++;
    if (outs !== OUT_RUN || Stall_cnt_o !== 4'd3) begin
      errors++; $display("FAIL mc_lat0_after: got %b cnt %0d want %b cnt 3", outs, Stall_cnt_o,
                         OUT_RUN);
    end
  endtask

  task automatic test_priority();
    Branch_taken_i = 1'b1;
    IDEX_MemRead_i = 1'b1; IDEX_RD_i = 5'd5; IFID_RS1_i = 5'd5;
    MC_start_i = 1'b1; MC_lat_i = 4'd2;
    #1;
    checks++;
    if (outs !== OUT_FLUSH) begin
      errors++; $display("FAIL prio_outs: got %b want %b", outs, OUT_FLUSH);
    end
    tick();
    idle();
    #1;
    checks++;
    if (outs !== OUT_RUN || Stall_cnt_o !== 4'd3) begin
      errors++; $display("FAIL prio_after: got %b cnt %0d want %b cnt 3", outs, Stall_cnt_o,
                         OUT_RUN);
    end
  endtask

  task automatic test_lu_with_mc();
    IDEX_MemRead_i = 1'b1; IDEX_RD_i = 5'd9; IFID_RS1_i = 5'd9;
    MC_start_i = 1'b1; MC_lat_i = 4'd2;
    #1;
    checks++;
    if (outs !== OUT_LU) begin
      errors++; $display("FAIL lumc_stall: got %b want %b", outs, OUT_LU);
    end
    tick();
    IDEX_MemRead_i = 1'b0;
    #1;
    checks++;
    if (outs !== OUT_RUN || Stall_cnt_o !== 4'd4) begin
      errors++; $display("FAIL lumc_retry: got %b cnt %0d want %b cnt 4", outs, Stall_cnt_o,
                         OUT_RUN);
    end
    tick();
    idle();
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (outs !== OUT_BUSY || Stall_cnt_o !== 4'(4 + i)) begin
        errors++; $display("FAIL lumc_busy_%0d: got %b cnt %0d want %b cnt %0d", i, outs,
                           Stall_cnt_o, OUT_BUSY, 4 + i);
      end
      tick();
    end
    #1;
    checks++;
    if (outs !== OUT_RUN || Stall_cnt_o !== 4'd6) begin
      errors++; $display("FAIL lumc_done: got %b cnt %0d want %b cnt 6", outs, Stall_cnt_o,
                         OUT_RUN);
    end
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    MC_start_i = 1'b1; MC_lat_i = 4'd6;
    #1;
    tick();
    idle();
    tick();
    tick();
    // Third stall cycle
    checks++;
    if (outs !== OUT_BUSY || Stall_cnt_o !== 4'd2) begin
      errors++; $display("FAIL rmid_pre: got %b cnt %0d want %b cnt 2", outs, Stall_cnt_o,
                         OUT_BUSY);
    end
    rst_n_i = 1'b0;
    #1;
    checks++;
    if (outs !== OUT_RST || Stall_cnt_o !== 4'd0) begin
      errors++; $display("FAIL rmid_async: got %b cnt %0d want %b cnt 0", outs, Stall_cnt_o,
                         OUT_RST);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick();
    checks++;
    if (outs !== OUT_RUN || Stall_cnt_o !== 4'd0) begin
      errors++; $display("FAIL rmid_release: got %b cnt %0d want %b cnt 0", outs, Stall_cnt_o,
                         OUT_RUN);
    end
    tick();
    checks++;
    if (outs !== OUT_RUN || Stall_cnt_o !== 4'd0) begin
      errors++; $display("FAIL rmid_run: got %b cnt %0d want %b cnt 0", outs, Stall_cnt_o,
                         OUT_RUN);
    end
  endtask

  task automatic test_back_to_back_saturation();
    apply_reset();
    for (int op = 0; op < 2; op++) begin
      MC_start_i = 1'b1; MC_lat_i = 4'd15;
      #1;
      checks++;
      if (outs !== OUT_RUN) begin
        errors++; $display("FAIL sat_issue_%0d: got %b want %b", op, outs, OUT_RUN);
      end
      tick();
      idle();
      for (int i = 1; i <= 15; i++) begin
        #1;
        checks++;
        if (outs !== OUT_BUSY || Stall_cnt_o !== ((op == 0) ? 4'(i - 1) : 4'd15)) begin
          errors++; $display("FAIL sat_busy_%0d_%0d: got %b cnt %0d want %b cnt %0d", op, i,
                             outs, Stall_cnt_o, OUT_BUSY, (op == 0) ? i - 1 : 15);
        end
        tick();
      end
      #1;
      checks++;
      if (outs !== OUT_RUN || Stall_cnt_o !== 4'd15) begin
        errors++; $display("FAIL sat_done_%0d: got %b cnt %0d want %b cnt 15", op, outs,
                           Stall_cnt_o, OUT_RUN);
      end
    end
  endtask

  initial begin
    idle();
    rst_n_i = 1'b0;
    test_reset();
    test_load_use();
    test_multicycle();
    test_priority();
    test_lu_with_mc();
    test_reset_mid_stall();
    test_back_to_back_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
